div_seq_ctrl: RTL and testbench
===============================

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 Parameter DBZ_QUOT, default 32'hFFFF_FFFF, SHALL be the quotient returned on divide-by-zero.
REQ-002 clk  in  1  sole clock, all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 start_valid  in  1  operand request.
REQ-005 start_ready  out  1  block idle, operands accepted.
REQ-006 dividend  in  32  unsigned dividend, sampled on accept.
REQ-007 divisor  in  32  unsigned divisor, sampled on accept.
REQ-008 res_valid  out  1  result available.
REQ-009 res_ready  in  1  consumer takes result.
REQ-010 quotient  out  32  unsigned quotient.
REQ-011 remainder  out  32  unsigned remainder.
REQ-012 dbz  out  1  divide-by-zero flag, qualified by res_valid.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, NORM, ITER, DONE.
REQ-015 start_ready SHALL equal (state==IDLE); accept = start_valid && start_ready.
REQ-016 On accept with divisor!=0: rem<=dividend, quo<=0, dsr<=divisor, next state NORM.
REQ-017 On accept with divisor==0: quo<=DBZ_QUOT, rem<=dividend, dbz<=1, next state DONE (no NORM/ITER).
REQ-018 NORM (one cycle): k = count of leading zeros of dsr (0..31); dsr<=dsr<<k via the barrel shifter (left mode, shift amount k); cnt<=k; next ITER.
REQ-019 ITER (one cycle per step): if rem>=dsr then rem<=rem-dsr and quo<={quo[30:0],1} else quo<={quo[30:0],0}; dsr<=dsr>>1; if cnt==0 next DONE else cnt<=cnt-1.
REQ-020 ITER SHALL execute exactly k+1 steps; all arithmetic 32-bit unsigned, no overflow possible.
REQ-021 Latency: accept edge = cycle 0; NORM in cycle 1; ITER cycles 2..k+2; res_valid first high in cycle k+3 (range 3..34). Divide-by-zero: res_valid in cycle 1.
REQ-022 DONE: res_valid=1; quotient, remainder, dbz SHALL hold stable while res_valid && !res_ready.
REQ-023 On res_valid && res_ready: next IDLE; dbz cleared; start_ready high the following cycle (no same-cycle re-accept).
REQ-024 quotient/remainder SHALL keep last result after handshake until next accept.
REQ-025 start_valid while busy SHALL be ignored; operand inputs ignored except on accept.
REQ-026 rst asserted in any state, including mid-ITER or DONE with pending result, SHALL abort and discard the operation.

Reset
REQ-027 On rst: state=IDLE, start_ready=1, busy=0, res_valid=0, dbz=0, quotient=0, remainder=0, cnt=0, dsr=0.
REQ-028 rst SHALL take priority over accept and over the result handshake in the same cycle.

Structure
REQ-029 Package div_pkg SHALL hold: state enum, DATA_W=32, SH_W=5, and the leading-zero-count function.
REQ-030 One sub-module instance SHALL be used: the team's 32-bit barrel shifter BarrelShifter32 (SH=k, LR=1, Input=dsr), used only in NORM; right shift by 1 in ITER is a local wire.
REQ-031 Target size 120-400 RTL lines; no multiplier or divider operators.

Verification
REQ-032 100/7 -> quotient 14, remainder 2, dbz 0, res_valid first in cycle 32 (k=29).
REQ-033 0xFFFF_FFFF/1 -> quotient 0xFFFF_FFFF, remainder 0, res_valid in cycle 34; 5/0x8000_0000 -> quotient 0, remainder 5, cycle 3.
REQ-034 1234/0 -> quotient 0xFFFF_FFFF, remainder 1234, dbz 1, res_valid in cycle 1.
REQ-035 Hold res_ready=0 for 10 cycles in DONE while toggling start_valid/operands -> outputs stable, start_ready 0, no new accept; release -> start_ready 1 next cycle.
REQ-036 Assert rst for one cycle mid-ITER of 1000/3 -> next cycle IDLE, res_valid 0, dbz 0, quotient 0, remainder 0; new 9/4 -> quotient 2, remainder 1.
REQ-037 Randomized back-to-back operands vs. reference model -> all quotient/remainder match, latency equals clz(divisor)+3.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_pkg
// Brief   : Shared types, widths and leading-zero count for the divider.
// Rev     : 1.0
// ============================================================================
package div_pkg;

    localparam int DATA_W = 32;
    localparam int SH_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Zero input yields an unspecified count; the divider only asks for non-zero values.
    function automatic logic [SH_W-1:0] clz32(input logic [DATA_W-1:0] v);
        logic [SH_W-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n     = n + 5'd1;
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_seq_ctrl_barrel.sv
`default_nettype none
// ============================================================================
// Module  : BarrelShifter32
// Brief   : 32-bit logarithmic barrel shifter, LR=1 shifts left, LR=0 right.
// Rev     : 1.0
// ============================================================================
module BarrelShifter32 (
    input  logic [4:0]  SH,
    input  logic        LR,
    input  logic [31:0] Input,
    output logic [31:0] Output
);

    logic [31:0] w_stage [0:5];

    assign w_stage[0] = Input;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            assign w_stage[gi+1] = !SH[gi] ? w_stage[gi] :
                                   (LR ? (w_stage[gi] << (1 << gi))
                                       : (w_stage[gi] >> (1 << gi)));
        end
    endgenerate

    assign Output = w_stage[5];

endmodule
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : div_seq_ctrl
// Brief   : Sequential 32-bit unsigned restoring divider with normalisation.
// Rev     : 1.0
// ============================================================================
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        dbz,
    output logic        busy
);

    state_t              r_state, w_state_n;
    logic [DATA_W-1:0]   r_quo, w_quo_n;
    logic [DATA_W-1:0]   r_rem, w_rem_n;
    logic [DATA_W-1:0]   r_dsr, w_dsr_n;
    logic [SH_W-1:0]     r_cnt, w_cnt_n;
    logic                r_dbz, w_dbz_n;

    logic [SH_W-1:0]     w_k;
    logic [DATA_W-1:0]   w_dsr_norm;
    logic [DATA_W-1:0]   w_dsr_shr;

    assign w_k       = clz32(r_dsr);
    assign w_dsr_shr = r_dsr >> 1;

    // Normalise the divisor so its MSB is set; the quotient then needs k+1 steps.
    BarrelShifter32 u_shift (
        .SH     (w_k),
        .LR     (1'b1),
        .Input  (r_dsr),
        .Output (w_dsr_norm)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_quo_n   = r_quo;
        w_rem_n   = r_rem;
        w_dsr_n   = r_dsr;
        w_cnt_n   = r_cnt;
        w_dbz_n   = r_dbz;
        case (r_state)
            IDLE: begin
                if (start_valid) begin
                    w_rem_n = dividend;
                    if (divisor == '0) begin
                        w_quo_n   = DBZ_QUOT;
                        w_dbz_n   = 1'b1;
                        w_state_n = DONE;
                    end else begin
                        w_quo_n   = '0;
                        w_dsr_n   = divisor;
                        w_dbz_n   = 1'b0;
                        w_state_n = NORM;
                    end
                end
            end
            NORM: begin
                w_dsr_n   = w_dsr_norm;
                w_cnt_n   = w_k;
                w_state_n = ITER;
            end
            ITER: begin
                if (r_rem >= r_dsr) begin
                    w_rem_n = r_rem - r_dsr;
                    w_quo_n = {r_quo[DATA_W-2:0], 1'b1};
                end else begin
                    w_quo_n = {r_quo[DATA_W-2:0], 1'b0};
                end
                w_dsr_n = w_dsr_shr;
                if (r_cnt == '0) w_state_n = DONE;
                else             w_cnt_n   = r_cnt - 5'd1;
            end
            DONE: begin
                if (res_ready) begin
                    w_dbz_n   = 1'b0;
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dsr <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else begin
            r_quo <= w_quo_n;
            r_rem <= w_rem_n;
            r_dsr <= w_dsr_n;
            r_cnt <= w_cnt_n;
            r_dbz <= w_dbz_n;
        end
    end

    assign start_ready = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign res_valid   = (r_state == DONE);
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign dbz         = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_div_seq_ctrl
// Brief   : Self-checking bench for div_seq_ctrl against an arithmetic model.
// Rev     : 1.0
// ============================================================================
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        dbz;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_seq_ctrl #(.DBZ_QUOT(32'hFFFF_FFFF)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .dbz         (dbz),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Expected latency from the position of the divisor's top set bit.
    function automatic int exp_latency(input logic [31:0] b);
        longint t;
        int     lg;
        if (b == 32'd0) return 1;
        t  = longint'(b);
        lg = 0;
        while (t > 1) begin
            t  = t / 2;
            lg = lg + 1;
        end
        return (31 - lg) + 3;
    endfunction

    // Issue one operation, measure latency, check result, then handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        int          cyc;
        int          w;
        logic [31:0] eq, er;
        eq = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        er = (b == 32'd0) ? a : a % b;
        start_valid = 1'b1;
        dividend    = a;
        divisor     = b;
        w = 0;
        while (!start_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!start_ready) check("start_ready_timeout", 32'(start_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        dividend    = $urandom;
        divisor     = $urandom;
        cyc = 1;
        while (!res_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("latency %0d/%0d", a, b), 32'(cyc), 32'(exp_latency(b)));
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("dbz", 32'(dbz), 32'(b == 32'd0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (quotient !== eq || remainder !== er || !res_valid)
                check("hold_stable", quotient, eq);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_after_hs", 32'({start_ready, busy, res_valid, dbz}), 32'b1000);
        check("quot_kept", quotient, eq);
    endtask

    initial begin
        logic [31:0] a, b, hq, hr;
        int          cyc;
        rst         = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        dividend    = 32'd0;
        divisor     = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_flags", 32'({start_ready, busy, res_valid, dbz}), 32'b1000);
        check("rst_quot", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'd100, 32'd7, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 0);
        run_op(32'd5, 32'h8000_0000, 0);
        run_op(32'd1234, 32'd0, 0);

        // Pending result held off while the producer side keeps poking.
        start_valid = 1'b1;
        dividend    = 32'd77;
        divisor     = 32'd5;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        while (!res_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        hq = quotient;
        hr = remainder;
        check("hold_q_init", hq, 32'd15);
        check("hold_r_init", hr, 32'd2);
        for (int i = 0; i < 10; i++) begin
            start_valid = i[0];
            dividend    = $urandom;
            divisor     = $urandom;
            @(negedge clk);
            if (quotient !== 32'd15 || remainder !== 32'd2 || start_ready !== 1'b0 || res_valid !== 1'b1)
                check("hold_dbg", quotient, 32'd15);
        end
        check("hold_q_end", quotient, 32'd15);
        check("hold_sr_end", 32'(start_ready), 32'd0);
        start_valid = 1'b0;
        res_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("hold_release_sr", 32'(start_ready), 32'd1);

        // Abort mid-iteration.
        start_valid = 1'b1;
        dividend    = 32'd1000;
        divisor     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_flags", 32'({start_ready, busy, res_valid, dbz}), 32'b1000);
        check("abort_quot", quotient, 32'd0);
        check("abort_rem", remainder, 32'd0);
        run_op(32'd9, 32'd4, 0);

        // Randomised back-to-back operations.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) b = 32'd0;
            if ($urandom_range(0, 5) == 0) a = a >> $urandom_range(0, 31);
            run_op(a, b, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
